ic_profile_lookup: RTL and testbench

IC_PROFILE_LOOKUP -- requirements
Module: ic_profile_lookup

---
 rtl/ic_profile_lookup.sv | 220 ++++++++++++++++++++++
 tb/tb_ic_profile_lookup.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ic_profile_lookup.sv
// ic_profile_lookup: sequential search of a fixed IC profile table.
// A request's part number is captured and the table is scanned one entry per
// cycle. The first (lowest-index) match is returned with its gate and tester
// codes. The result is held until the consumer takes it.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   req_valid  - lookup request present
//   req_ready  - block accepts a request (decoded from state, IDLE only)
//   icNumber   - part number to look up
//   rsp_valid  - result valid (registered)
//   rsp_ready  - consumer takes the result
//   found      - part number matched an entry (registered)
//   gate       - gate code of the matching entry (registered)
//   tester     - tester code of the matching entry (registered)
//   hit_index  - index of the matching entry (registered)
//
// Optional feature: define ICDEC_LAST_HIT_EN to add a last-hit register.
// A repeat of the most recent found part number then completes one edge
// after accept.
module ic_profile_lookup #(
    parameter int unsigned NUM_ENTRIES = 17,
    parameter int unsigned ID_W        = 32,
    parameter int unsigned GATE_W      = 3,
    parameter int unsigned TESTER_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_W-1:0]     icNumber,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                found,
    output logic [GATE_W-1:0]   gate,
    output logic [TESTER_W-1:0] tester,
    output logic [5:0]          hit_index
);

    localparam int unsigned IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ID_W-1:0]     icnum_q, icnum_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                found_q, found_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [TESTER_W-1:0] tester_q, tester_d;
    logic [IDX_W-1:0]    hit_q, hit_d;

`ifdef ICDEC_LAST_HIT_EN
    logic                lh_valid_q, lh_valid_d;
    logic [ID_W-1:0]     lh_id_q, lh_id_d;
    logic [GATE_W-1:0]   lh_gate_q, lh_gate_d;
    logic [TESTER_W-1:0] lh_tester_q, lh_tester_d;
    logic [IDX_W-1:0]    lh_hit_q, lh_hit_d;
`endif

    // Profile table entry at the current search index; indices 17+ never match
    logic [ID_W-1:0]     tbl_id;
    logic [GATE_W-1:0]   tbl_gate;
    logic [TESTER_W-1:0] tbl_tester;
    logic                tbl_ok;
    logic                tbl_hit;

    always_comb begin
        tbl_id     = '0;
        tbl_gate   = '0;
        tbl_tester = '0;
        tbl_ok     = 1'b1;
        case (idx_q)
            6'd0:  begin tbl_id = ID_W'(32'd7400);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b001); end
            6'd1:  begin tbl_id = ID_W'(32'd7403);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b001); end
            6'd2:  begin tbl_id = ID_W'(32'd7408);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b001); end
            6'd3:  begin tbl_id = ID_W'(32'd7409);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b001); end
            6'd4:  begin tbl_id = ID_W'(32'd7432);  tbl_gate = GATE_W'(3'b001); tbl_tester = TESTER_W'(3'b001); end
            6'd5:  begin tbl_id = ID_W'(32'd7486);  tbl_gate = GATE_W'(3'b100); tbl_tester = TESTER_W'(3'b001); end
            6'd6:  begin tbl_id = ID_W'(32'd74132); tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b001); end
            6'd7:  begin tbl_id = ID_W'(32'd7410);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b010); end
            6'd8:  begin tbl_id = ID_W'(32'd7411);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b010); end
            6'd9:  begin tbl_id = ID_W'(32'd7412);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b010); end
            6'd10: begin tbl_id = ID_W'(32'd7427);  tbl_gate = GATE_W'(3'b011); tbl_tester = TESTER_W'(3'b010); end
            6'd11: begin tbl_id = ID_W'(32'd7420);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b011); end
            6'd12: begin tbl_id = ID_W'(32'd7421);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b011); end
            6'd13: begin tbl_id = ID_W'(32'd7430);  tbl_gate = GATE_W'(3'b010); tbl_tester = TESTER_W'(3'b100); end
            6'd14: begin tbl_id = ID_W'(32'd7404);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b000); end
            6'd15: begin tbl_id = ID_W'(32'd7405);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b000); end
            6'd16: begin tbl_id = ID_W'(32'd7414);  tbl_gate = GATE_W'(3'b000); tbl_tester = TESTER_W'(3'b000); end
            default: tbl_ok = 1'b0;
        endcase
    end

    assign tbl_hit = tbl_ok && (tbl_id == icnum_q);

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            icnum_q     <= '0;
            rsp_valid_q <= 1'b0;
            found_q     <= 1'b0;
            gate_q      <= '0;
            tester_q    <= '0;
            hit_q       <= '0;
`ifdef ICDEC_LAST_HIT_EN
            lh_valid_q  <= 1'b0;
            lh_id_q     <= '0;
            lh_gate_q   <= '0;
            lh_tester_q <= '0;
            lh_hit_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            icnum_q     <= icnum_d;
            rsp_valid_q <= rsp_valid_d;
            found_q     <= found_d;
            gate_q      <= gate_d;
            tester_q    <= tester_d;
            hit_q       <= hit_d;
`ifdef ICDEC_LAST_HIT_EN
            lh_valid_q  <= lh_valid_d;
            lh_id_q     <= lh_id_d;
            lh_gate_q   <= lh_gate_d;
            lh_tester_q <= lh_tester_d;
            lh_hit_q    <= lh_hit_d;
`endif
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        icnum_d     = icnum_q;
        rsp_valid_d = rsp_valid_q;
        found_d     = found_q;
        gate_d      = gate_q;
        tester_d    = tester_q;
        hit_d       = hit_q;
`ifdef ICDEC_LAST_HIT_EN
        lh_valid_d  = lh_valid_q;
        lh_id_d     = lh_id_q;
        lh_gate_d   = lh_gate_q;
        lh_tester_d = lh_tester_q;
        lh_hit_d    = lh_hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    icnum_d = icNumber;
                    idx_d   = '0;
                    state_d = SEARCH;
`ifdef ICDEC_LAST_HIT_EN
                    // Repeat of the last found part: serve the stored result
                    if (lh_valid_q && (icNumber == lh_id_q)) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        found_d     = 1'b1;
                        gate_d      = lh_gate_q;
                        tester_d    = lh_tester_q;
                        hit_d       = lh_hit_q;
                    end
`endif
                end
            end
            SEARCH: begin
                if (tbl_hit) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    found_d     = 1'b1;
                    gate_d      = tbl_gate;
                    tester_d    = tbl_tester;
                    hit_d       = idx_q;
`ifdef ICDEC_LAST_HIT_EN
                    lh_valid_d  = 1'b1;
                    lh_id_d     = icnum_q;
                    lh_gate_d   = tbl_gate;
                    lh_tester_d = tbl_tester;
                    lh_hit_d    = idx_q;
`endif
                end else if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    found_d     = 1'b0;
                    gate_d      = '0;
                    tester_d    = '0;
                    hit_d       = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Hold the result until taken; new requests wait for IDLE
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    found_d     = 1'b0;
                    gate_d      = '0;
                    tester_d    = '0;
                    hit_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign found     = found_q;
    assign gate      = gate_q;
    assign tester    = tester_q;
    assign hit_index = hit_q;

endmodule

// File: tb/tb_ic_profile_lookup.sv
// Bench for ic_profile_lookup: a 17-entry instance and an 8-entry instance.
// Expected results are queued when a request is driven and compared when the
// response appears.
module tb_ic_profile_lookup;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv [2];
    logic        rr [2];
    logic [31:0] icn [2];
    logic        sv [2];
    logic        sr [2];
    logic        fd [2];
    logic [2:0]  gt [2];
    logic [2:0]  ts [2];
    logic [5:0]  hx [2];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       found;
        logic [2:0] gate;
        logic [2:0] tester;
        logic [5:0] hit;
        int         lat;
    } exp_t;

    exp_t sbq[$];

    int         tab_id [17]   = '{7400, 7403, 7408, 7409, 7432, 7486, 74132, 7410, 7411,
                                  7412, 7427, 7420, 7421, 7430, 7404, 7405, 7414};
    logic [2:0] tab_gate [17] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b100, 3'b010,
                                  3'b010, 3'b000, 3'b010, 3'b011, 3'b010, 3'b000, 3'b010,
                                  3'b000, 3'b000, 3'b000};
    logic [2:0] tab_test [17] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                                  3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b100,
                                  3'b000, 3'b000, 3'b000};

    logic lh_v [2];
    int   lh_id [2];
    exp_t lh_e [2];

    always #5 clk = ~clk;

    ic_profile_lookup u_dut (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .icNumber(icn[0]),
        .rsp_valid(sv[0]), .rsp_ready(sr[0]), .found(fd[0]), .gate(gt[0]), .tester(ts[0]),
        .hit_index(hx[0])
    );

    ic_profile_lookup #(.NUM_ENTRIES(8)) u_dut8 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .icNumber(icn[1]),
        .rsp_valid(sv[1]), .rsp_ready(sr[1]), .found(fd[1]), .gate(gt[1]), .tester(ts[1]),
        .hit_index(hx[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: first match within the searched range
    function automatic exp_t model(input int sel, input int id);
        exp_t e;
        int   n;
        n = (sel == 1) ? 8 : 17;
        e.found = 1'b0; e.gate = '0; e.tester = '0; e.hit = '0; e.lat = n;
        for (int i = 0; i < n; i++) begin
            if (tab_id[i] == id) begin
                e.found = 1'b1; e.gate = tab_gate[i]; e.tester = tab_test[i];
                e.hit = 6'(i); e.lat = i + 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic push_exp(input int sel, input int id);
        exp_t e;
        e = model(sel, id);
`ifdef ICDEC_LAST_HIT_EN
        if (lh_v[sel] && lh_id[sel] == id) begin
            e = lh_e[sel];
            e.lat = 1;
        end
        if (e.found) begin
            lh_v[sel] = 1'b1; lh_id[sel] = id; lh_e[sel] = e;
        end
`endif
        sbq.push_back(e);
    endtask

    // Called #1 after the accept edge; counts edges until rsp_valid and compares
    task automatic wait_rsp(input int sel, output exp_t e);
        int n;
        n = 0;
        e = sbq.pop_front();
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (sv[sel]) break;
            if (n >= 100) begin
                check("rsp_timeout", 32'(0), 32'(1));
                return;
            end
        end
        check("latency", 32'(n), 32'(e.lat));
        check("found", 32'(fd[sel]), 32'(e.found));
        check("gate", 32'(gt[sel]), 32'(e.gate));
        check("tester", 32'(ts[sel]), 32'(e.tester));
        check("hit_index", 32'(hx[sel]), 32'(e.hit));
    endtask

    task automatic take_rsp(input int sel);
        @(negedge clk); sr[sel] = 1'b1;
        @(posedge clk); #1; sr[sel] = 1'b0;
    endtask

    task automatic lookup(input int sel, input int id, input bit stall);
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(rr[sel]), 32'(1));
        icn[sel] = 32'(id); rv[sel] = 1'b1;
        push_exp(sel, id);
        @(posedge clk); #1;
        if (!stall) rv[sel] = 1'b0;
        wait_rsp(sel, e);
        if (stall) begin
            // Consumer stalls with a new request pending
            repeat (5) begin
                @(posedge clk); #1;
                check("stall_rsp_valid", 32'(sv[sel]), 32'(1));
                check("stall_req_ready", 32'(rr[sel]), 32'(0));
                check("stall_found", 32'(fd[sel]), 32'(e.found));
                check("stall_gate", 32'(gt[sel]), 32'(e.gate));
                check("stall_tester", 32'(ts[sel]), 32'(e.tester));
                check("stall_hit", 32'(hx[sel]), 32'(e.hit));
            end
            @(negedge clk); sr[sel] = 1'b1;
            @(posedge clk); #1; sr[sel] = 1'b0;
            check("release_idle_rdy", 32'(rr[sel]), 32'(1));
            check("release_rsp_low", 32'(sv[sel]), 32'(0));
            push_exp(sel, id);
            @(posedge clk); #1;
            rv[sel] = 1'b0;
            check("reaccept_busy", 32'(rr[sel]), 32'(0));
            wait_rsp(sel, e);
        end
        take_rsp(sel);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int s = 0; s < 2; s++) lh_v[s] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0; sr[s] = 1'b0; icn[s] = '0; lh_v[s] = 1'b0; lh_id[s] = 0;
        end
        do_reset();
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(rr[s]), 32'(1));
            check("rst_rsp_valid", 32'(sv[s]), 32'(0));
            check("rst_found", 32'(fd[s]), 32'(0));
            check("rst_gate", 32'(gt[s]), 32'(0));
            check("rst_tester", 32'(ts[s]), 32'(0));
            check("rst_hit", 32'(hx[s]), 32'(0));
        end

        lookup(0, 7400, 1'b0);
        lookup(0, 7414, 1'b0);
        lookup(0, 7499, 1'b0);
        lookup(0, 7432, 1'b0);
        lookup(0, 7408, 1'b1);
        lookup(0, 7430, 1'b0);
        lookup(0, 7430, 1'b0);
        lookup(1, 7410, 1'b0);
        lookup(1, 7409, 1'b0);
        lookup(1, 7405, 1'b0);

        // Reset in the middle of a search aborts it silently
        @(negedge clk); icn[0] = 32'd7427; rv[0] = 1'b1;
        @(posedge clk); #1; rv[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("abort_req_ready", 32'(rr[0]), 32'(1));
        check("abort_rsp_valid", 32'(sv[0]), 32'(0));
        @(negedge clk); reset = 1'b0;
        for (int s = 0; s < 2; s++) lh_v[s] = 1'b0;
        saw = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (sv[0]) saw = 1'b1;
        end
        check("abort_no_rsp", 32'(saw), 32'(0));

        lookup(0, 7400, 1'b0);
        lookup(0, 7486, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
